// File: rtl/trap_peak_detector_pkg.sv
// Shared types and constants for the trapezoid-filter peak detector.
package trap_peak_detector_pkg;

  // Filter datapath width; detector samples carry one extra sign bit.
  localparam int SIZE_FILTER_DATA = 15;
  localparam int DEF_DATA_W       = SIZE_FILTER_DATA + 1;
  localparam int DEF_TS_W         = 32;
  localparam int DEF_WIDTH_W      = 8;

  // Bit positions inside peak_flags.
  localparam int FLAG_LONG   = 0;
  localparam int FLAG_RETRIG = 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TRACK    = 2'd1,
    WAIT_LOW = 2'd2,
    HOLDOFF  = 2'd3
  } det_state_t;

  // Layout of one event record at the default widths.
  typedef struct packed {
    logic signed [DEF_DATA_W-1:0] amp;
    logic [DEF_TS_W-1:0]          ts;
    logic [DEF_WIDTH_W-1:0]       width;
    logic [1:0]                   flags;
  } peak_event_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/trap_peak_detector_peak_event_reg.sv
// Single-entry valid/ready output register. A new record is taken when the
// slot is empty or being drained this cycle; otherwise it is dropped and
// counted.
module peak_event_reg
  import trap_peak_detector_pkg::*;
#(
  parameter int REC_W = 58
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [REC_W-1:0] load_rec,
  output logic [REC_W-1:0] out_rec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      drop_cnt
);

  logic [REC_W-1:0] rec_reg;
  logic             valid_reg;
  logic [15:0]      drop_reg;

  // Load / hold / drain of the record slot and the drop counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rec_reg   <= '0;
      valid_reg <= 1'b0;
      drop_reg  <= '0;
    end else if (load) begin
      if (!valid_reg || out_ready) begin
        rec_reg   <= load_rec;
        valid_reg <= 1'b1;
      end else begin
        drop_reg <= sat_inc16(drop_reg);
      end
    end else if (valid_reg && out_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign out_rec   = rec_reg;
  assign out_valid = valid_reg;
  assign drop_cnt  = drop_reg;

endmodule

// File: rtl/trap_peak_detector.sv
// Hysteresis pulse detector on the trapezoid-filter output: measures flat-top
// maximum, its sample index and the width above threshold, one record per pulse.
module trap_peak_detector
  import trap_peak_detector_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TS_W        = DEF_TS_W,
  parameter int MIN_WIDTH   = 4,
  parameter int MAX_WIDTH   = 255,
  parameter int HOLDOFF_CYC = 16,
  parameter int WIDTH_W     = DEF_WIDTH_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] thr_hi,
  input  logic signed [DATA_W-1:0] thr_lo,
  output logic signed [DATA_W-1:0] peak_amp,
  output logic [TS_W-1:0]          peak_ts,
  output logic [WIDTH_W-1:0]       peak_width,
  output logic [1:0]               peak_flags,
  output logic                     peak_valid,
  input  logic                     peak_ready,
  output logic [15:0]              drop_cnt
);

  localparam int HC_W  = (HOLDOFF_CYC < 1) ? 1 : $clog2(HOLDOFF_CYC + 1);
  localparam int REC_W = DATA_W + TS_W + WIDTH_W + 2;

  det_state_t               state_reg, state_next;
  logic [TS_W-1:0]          ts_reg;
  logic [WIDTH_W-1:0]       width_reg, width_next;
  logic signed [DATA_W-1:0] max_reg, max_next;
  logic [TS_W-1:0]          max_ts_reg, max_ts_next;
  logic [HC_W-1:0]          hold_reg, hold_next;
  logic                     retrig_reg, retrig_next;
  logic                     emit, emit_long;
  logic                     ge_hi, lt_lo;
  logic [WIDTH_W-1:0]       width_inc;
  logic [REC_W-1:0]         emit_rec, out_rec;

  assign ge_hi     = (in_data >= thr_hi);
  assign lt_lo     = (in_data < thr_lo);
  assign width_inc = width_reg + WIDTH_W'(1);

  // Sample index: counts every accepted sample, independent of state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts_reg <= '0;
    end else if (in_valid) begin
      ts_reg <= ts_reg + TS_W'(1);
    end
  end

  // Detector state and per-pulse measurement registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      width_reg  <= '0;
      max_reg    <= '0;
      max_ts_reg <= '0;
      hold_reg   <= '0;
      retrig_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      width_reg  <= width_next;
      max_reg    <= max_next;
      max_ts_reg <= max_ts_next;
      hold_reg   <= hold_next;
      retrig_reg <= retrig_next;
    end
  end

  // Next-state and emit decision; frozen while no sample is accepted.
  always_comb begin
    state_next  = state_reg;
    width_next  = width_reg;
    max_next    = max_reg;
    max_ts_next = max_ts_reg;
    hold_next   = hold_reg;
    retrig_next = retrig_reg;
    emit        = 1'b0;
    emit_long   = 1'b0;

    if (!enable) begin
      // Abandon any partial pulse; the output slot is left alone.
      state_next = IDLE;
    end else if (in_valid) begin
      unique case (state_reg)
        IDLE: begin
          if (ge_hi) begin
            state_next  = TRACK;
            max_next    = in_data;
            max_ts_next = ts_reg;
            width_next  = WIDTH_W'(1);
          end
        end
        TRACK: begin
          if (lt_lo) begin
            // Releasing sample is not part of the pulse width.
            state_next = HOLDOFF;
            hold_next  = '0;
            emit       = (width_reg >= WIDTH_W'(MIN_WIDTH));
          end else begin
            width_next = width_inc;
            // Strict compare keeps the earliest index on a flat top.
            if (in_data > max_reg) begin
              max_next    = in_data;
              max_ts_next = ts_reg;
            end
            if (width_inc == WIDTH_W'(MAX_WIDTH)) begin
              state_next = WAIT_LOW;
              emit       = 1'b1;
              emit_long  = 1'b1;
            end
          end
        end
        WAIT_LOW: begin
          if (lt_lo) begin
            state_next = HOLDOFF;
            hold_next  = '0;
          end
        end
        HOLDOFF: begin
          if (ge_hi) begin
            retrig_next = 1'b1;
          end
          if (hold_reg == HC_W'(HOLDOFF_CYC - 1)) begin
            state_next = IDLE;
          end else begin
            hold_next = hold_reg + HC_W'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end

    if (emit) begin
      retrig_next = 1'b0;
    end
  end

  // The *_next values already hold the final measurement for either close path.
  always_comb begin
    emit_rec = {max_next, max_ts_next, width_next, retrig_reg, emit_long};
  end

  peak_event_reg #(
    .REC_W(REC_W)
  ) u_event_reg (
    .clk      (clk),
    .reset    (reset),
    .load     (emit),
    .load_rec (emit_rec),
    .out_rec  (out_rec),
    .out_valid(peak_valid),
    .out_ready(peak_ready),
    .drop_cnt (drop_cnt)
  );

  assign {peak_amp, peak_ts, peak_width, peak_flags} = out_rec;

endmodule

// File: doc/trap_peak_detector.md
Name: trap_peak_detector

Overview:
Consumes the signed trapezoid-filter output stream and detects pulses with a hysteresis threshold. For each pulse it measures the flat-top maximum, the sample index of that maximum and the width above threshold. One event record per pulse goes out on a valid/ready interface to the event packer/readout. Sits directly downstream of the trapezoid filter in the ADC channel chain.

Parameters:
DATA_W, SIZE_FILTER_DATA+1, width of filter output sample and thresholds (signed two's complement)
TS_W, 32, width of sample-index timestamp
MIN_WIDTH, 4, minimum samples above threshold for a pulse to be reported
MAX_WIDTH, 255, width at which a pulse is force-closed and flagged LONG
HOLDOFF_CYC, 16, dead time in accepted samples after a pulse closes
WIDTH_W, 8, width of peak_width; must hold MAX_WIDTH

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  asynchronous, active-low reset
enable  in  1  detector enable
in_data  in  DATA_W  signed filter output sample
in_valid  in  1  in_data valid this cycle
thr_hi  in  DATA_W  signed arm threshold (sample >= thr_hi arms)
thr_lo  in  DATA_W  signed release threshold (sample < thr_lo releases)
peak_amp  out  DATA_W  signed maximum of pulse
peak_ts  out  TS_W  sample index of first occurrence of maximum
peak_width  out  WIDTH_W  accepted samples while armed
peak_flags  out  2  bit0 LONG, bit1 RETRIG
peak_valid  out  1  event record valid
peak_ready  in  1  consumer accepts record
drop_cnt  out  16  events lost to backpressure, saturating

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; ts counter 0; retrig pending 0.
- Sample index counter: +1 per accepted sample (in_valid=1), wraps modulo 2^TS_W. Value tagged to a sample = counter before increment. Counts regardless of state/enable.
- in_valid=0: state, width, holdoff counters frozen; output handshake still active.
- All comparisons signed.
- States:
  IDLE: accepted sample >= thr_hi and enable -> TRACK. Load max=sample, max_ts=index, width=1.
  TRACK: per accepted sample, width+1. If sample > max (strict): max/max_ts update, so ties keep the earliest index.
    Sample < thr_lo: pulse closes. This sample is not counted in width.
    Close with width >= MIN_WIDTH -> emit, then HOLDOFF. Close with width < MIN_WIDTH -> discard, then HOLDOFF.
    Width reaches MAX_WIDTH -> emit with LONG, then WAIT_LOW.
  WAIT_LOW: accepted sample < thr_lo -> HOLDOFF.
  HOLDOFF: counts HOLDOFF_CYC accepted samples, then IDLE. Any sample >= thr_hi here sets retrig pending.
- RETRIG: copied into the next emitted event's flag bit1, then cleared when that event is emitted.
- enable=0: next cycle forces IDLE from any state. Partial pulse discarded. Pending output record kept.
- Emit latency: record registered on the clk edge that accepts the closing sample; peak_valid high the following cycle.
- Handshake: record held stable while peak_valid & !peak_ready. peak_valid drops after a cycle with peak_ready=1 unless a new emit arrives that same cycle, in which case the new record loads and peak_valid stays 1.
- Emit while peak_valid=1 and peak_ready=0: new event dropped, held record kept, drop_cnt+1 saturating at 16'hFFFF.
- thr_lo > thr_hi: allowed; rules apply literally (pulse may close on the next sample).
- Reset mid-pulse or with record pending: everything cleared, nothing emitted.

Decomposition:
- Add to package_settings: TS_W and the peak_flags bit indices (FLAG_LONG=0, FLAG_RETRIG=1).
- Add to package_settings: typedef enum for states IDLE/TRACK/WAIT_LOW/HOLDOFF.
- Add to package_settings: packed struct peak_event_t {amp, ts, width, flags}.
- One sub-module, peak_event_reg: single-entry valid/ready output register with drop counting.

Test Plan:
- thr_hi=100, thr_lo=50, samples 0,0,120,300,500,400,200,40 (indices 0-7), ready=1 -> one event amp=500, ts=4, width=5, flags=0, valid the cycle after sample 7.
- Samples 0,150,160,30 -> width 2 < MIN_WIDTH, no event. Samples -200,-5 with thr_hi=100 -> stays IDLE (signed compare).
- 300 consecutive samples of 200 -> event after 255th armed sample: width=255, flags=01, amp=200, ts=first 200 index. No second event until the input falls below 50 and 16 holdoff samples elapse.
- peak_ready=0, two valid pulses -> first record held stable, second dropped, drop_cnt=1. Raise ready -> first record delivered, peak_valid low next cycle.
- Second pulse peaking during holdoff -> not reported. Next reported pulse has flags=10.
- Ties 0,200,500,500,100,0 -> ts of first 500. Async reset asserted during TRACK -> outputs 0 immediately, no event after release.
